// File: rtl/sr_lsu_pkg.sv
// sr_lsu_pkg: shared RAM write-enable codes, access size codes and LSU FSM states for the schoolRISCV data path.
package sr_lsu_pkg;
    localparam logic [1:0] WBE_NO = 2'b00;
    localparam logic [1:0] WBE_B  = 2'b01;
    localparam logic [1:0] WBE_H  = 2'b10;
    localparam logic [1:0] WBE_W  = 2'b11;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    typedef enum logic [1:0] {LSU_IDLE, LSU_WRITE, LSU_READ, LSU_RESP} lsu_state_t;

    // size 11 behaves as a word access
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] a);
        return size == LSU_SIZE_B ? 1'b0 : size == LSU_SIZE_H ? a[0] : |a;
    endfunction
endpackage

// File: rtl/sr_lsu_extend.sv
// sr_lsu_extend: sign/zero extension of RAM read data to a 32-bit load result.
module sr_lsu_extend
    import sr_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);
    logic sb, sh;
    assign sb = ~is_unsigned & rdata[7];
    assign sh = ~is_unsigned & rdata[15];
    always_comb ext = size == LSU_SIZE_B ? {{24{sb}}, rdata[7:0]} :
                      size == LSU_SIZE_H ? {{16{sh}}, rdata[15:0]} : rdata;
endmodule

// File: rtl/sr_lsu.sv
// sr_lsu: single-outstanding load/store unit driving the byte-addressable data RAM.
// Define SR_LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses with resp_err.
module sr_lsu
    import sr_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        write_byte_en,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    input  logic [31:0]       rdata
);
    lsu_state_t state, next;
    logic we_r, uns_r, mis, accept;
    logic [1:0] size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0] wdata_r, ext;

    sr_lsu_extend u_ext (.rdata(rdata), .size(size_r), .is_unsigned(uns_r), .ext(ext));

`ifdef SR_LSU_MISALIGN_TRAP_EN
    assign mis = lsu_misaligned(req_size, req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign accept     = state == LSU_IDLE && req_valid;
    assign req_ready  = state == LSU_IDLE;
    assign resp_valid = state == LSU_RESP;
    assign raddr      = addr_r;
    assign waddr      = addr_r;
    assign wdata      = wdata_r;

    always_comb begin
        next          = state;
        write_byte_en = WBE_NO;
        case (state)
            LSU_IDLE:  next = !req_valid ? LSU_IDLE : mis ? LSU_RESP : req_we ? LSU_WRITE : LSU_READ;
            LSU_WRITE: begin
                next          = LSU_RESP;
                write_byte_en = size_r == LSU_SIZE_B ? WBE_B : size_r == LSU_SIZE_H ? WBE_H : WBE_W;
            end
            LSU_READ:  next = LSU_RESP;
            default:   next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= LSU_IDLE;
        else     state <= next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r       <= 1'b0;
            uns_r      <= 1'b0;
            size_r     <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                we_r    <= req_we;
                uns_r   <= req_unsigned;
                size_r  <= req_size;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (accept && mis) resp_rdata <= '0;
            if (state == LSU_READ || state == LSU_WRITE) resp_rdata <= we_r ? 32'h0 : ext;
        end
    end

`ifdef SR_LSU_MISALIGN_TRAP_EN
    // resp_err only changes on entry to RESP so it is stable outside the response
    always_ff @(posedge clk or posedge rst)
        if (rst)                                         resp_err <= 1'b0;
        else if (accept && mis)                          resp_err <= 1'b1;
        else if (state == LSU_READ || state == LSU_WRITE) resp_err <= 1'b0;
`else
    assign resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_sr_lsu.sv
// tb_sr_lsu: directed self-checking bench for sr_lsu with a byte-addressed RAM model.
module tb_sr_lsu;
    import sr_lsu_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, raddr, waddr, wdata, rdata;
    logic [1:0]  write_byte_en;

    always #5 clk = ~clk;

    sr_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .write_byte_en(write_byte_en), .raddr(raddr), .waddr(waddr), .wdata(wdata), .rdata(rdata)
    );

    logic [7:0] mem [0:255];
    logic       mem_init = 1'b1;
    logic [7:0] wa, ra;
    assign wa = waddr[7:0];
    assign ra = raddr[7:0];

    always @(posedge clk)
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (write_byte_en == WBE_B) begin
            mem[wa] <= wdata[7:0];
        end else if (write_byte_en == WBE_H) begin
            mem[wa] <= wdata[7:0];
            mem[wa + 8'd1] <= wdata[15:8];
        end else if (write_byte_en == WBE_W) begin
            mem[wa] <= wdata[7:0];
            mem[wa + 8'd1] <= wdata[15:8];
            mem[wa + 8'd2] <= wdata[23:16];
            mem[wa + 8'd3] <= wdata[31:24];
        end

    always_comb rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

    int wbe_cnt = 0;
    logic [1:0] wbe_last = WBE_NO;
    always @(negedge clk)
        if (write_byte_en != WBE_NO) begin
            wbe_cnt++;
            wbe_last = write_byte_en;
        end

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // called #1 after an edge with the unit idle; scrambles inputs after acceptance
    task automatic access(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err, output int lat);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns; req_addr = ~a; req_wdata = ~wd;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        err = resp_err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat, n, rdy_cnt, rsp_cnt;
    logic [8:0]  rdy_map;

    initial begin
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_wbe", 32'(write_byte_en), 32'(WBE_NO));
        check("reset_addr", raddr | waddr | wdata, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        n = wbe_cnt;
        access(1'b1, LSU_SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat);
        check("sw_rdata_zero", rd, 32'h0);
        check("sw_latency", 32'(lat), 32'd2);
        check("sw_wbe_cycles", 32'(wbe_cnt - n), 32'd1);
        check("sw_wbe_code", 32'(wbe_last), 32'(WBE_W));
        access(1'b0, LSU_SIZE_W, 1'b0, 32'h10, 32'h0, rd, err, lat);
        check("lw_10", rd, 32'hDEADBEEF);
        check("lw_latency", 32'(lat), 32'd2);
        check("lw_err", 32'(err), 32'd0);
        access(1'b0, LSU_SIZE_W, 1'b1, 32'h10, 32'h0, rd, err, lat);
        check("lw_unsigned_ignored", rd, 32'hDEADBEEF);

        n = wbe_cnt;
        access(1'b1, LSU_SIZE_B, 1'b0, 32'h21, 32'h11223380, rd, err, lat);
        check("sb_wbe_code", 32'(wbe_last), 32'(WBE_B));
        check("sb_wbe_cycles", 32'(wbe_cnt - n), 32'd1);
        access(1'b0, LSU_SIZE_B, 1'b0, 32'h21, 32'h0, rd, err, lat);
        check("lb_21", rd, 32'hFFFFFF80);
        access(1'b0, LSU_SIZE_B, 1'b1, 32'h21, 32'h0, rd, err, lat);
        check("lbu_21", rd, 32'h00000080);
        access(1'b0, LSU_SIZE_W, 1'b0, 32'h20, 32'h0, rd, err, lat);
        check("lw_20_neighbours", rd, 32'h23228020);

        access(1'b1, LSU_SIZE_H, 1'b0, 32'h30, 32'h12348001, rd, err, lat);
        check("sh_wbe_code", 32'(wbe_last), 32'(WBE_H));
        access(1'b0, LSU_SIZE_H, 1'b0, 32'h30, 32'h0, rd, err, lat);
        check("lh_30", rd, 32'hFFFF8001);
        access(1'b0, LSU_SIZE_H, 1'b1, 32'h30, 32'h0, rd, err, lat);
        check("lhu_30", rd, 32'h00008001);
        access(1'b0, LSU_SIZE_W, 1'b0, 32'h30, 32'h0, rd, err, lat);
        check("lw_30_neighbours", rd, 32'h33328001);

        access(1'b1, 2'b11, 1'b0, 32'h50, 32'hCAFEF00D, rd, err, lat);
        check("s_size3_wbe", 32'(wbe_last), 32'(WBE_W));
        access(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, rd, err, lat);
        check("l_size3", rd, 32'hCAFEF00D);

        n = wbe_cnt;
        access(1'b0, LSU_SIZE_W, 1'b0, 32'h13, 32'h0, rd, err, lat);
`ifdef SR_LSU_MISALIGN_TRAP_EN
        check("mis_err", 32'(err), 32'd1);
        check("mis_rdata", rd, 32'h0);
        check("mis_latency", 32'(lat), 32'd1);
        check("mis_no_write", 32'(wbe_cnt - n), 32'd0);
        access(1'b0, LSU_SIZE_W, 1'b0, 32'h10, 32'h0, rd, err, lat);
        check("aligned_clears_err", 32'(err), 32'd0);
`else
        check("mis_err", 32'(err), 32'd0);
        check("mis_rdata", rd, 32'h161514DE);
        check("mis_latency", 32'(lat), 32'd2);
        check("mis_no_write", 32'(wbe_cnt - n), 32'd0);
`endif

        rdy_cnt = 0; rsp_cnt = 0; rdy_map = '0;
        req_valid = 1'b1; req_we = 1'b0; req_size = LSU_SIZE_W; req_unsigned = 1'b0; req_addr = 32'h10;
        for (int i = 0; i < 9; i++) begin
            rdy_map[i] = req_ready;
            rdy_cnt += int'(req_ready);
            rsp_cnt += int'(resp_valid);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("b2b_ready_pattern", 32'(rdy_map), 32'h049);
        check("b2b_ready_count", 32'(rdy_cnt), 32'd3);
        check("b2b_resp_count", 32'(rsp_cnt), 32'd3);
        check("b2b_last_rdata", resp_rdata, 32'hDEADBEEF);

        req_valid = 1'b1; req_we = 1'b1; req_size = LSU_SIZE_W; req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_pre_wbe", 32'(write_byte_en), 32'(WBE_W));
        rst = 1'b1;
        #1;
        check("rst_wbe_drop", 32'(write_byte_en), 32'(WBE_NO));
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
        check("rst_bus", raddr | waddr | wdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk) rst = 1'b0;
        check("rst_mem_40", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h43424140);
        @(posedge clk); #1;
        access(1'b0, LSU_SIZE_W, 1'b0, 32'h40, 32'h0, rd, err, lat);
        check("post_rst_lw_40", rd, 32'h43424140);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
